// File: rtl/calc_sequencer.sv
// Walks an operand range, feeds each {b,a} pair to the adder, packs two sums per result word.
// Latency: start in T, first read at T+1, done at T+1+3N+ceil(N/2); empty range done at T+1.
// No backpressure: memory is always ready; start_i outside IDLE is ignored.
module calc_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   rd_start_addr_i,
    input  logic [ADDR_W-1:0]   rd_end_addr_i,
    input  logic [ADDR_W-1:0]   wr_start_addr_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                mem_rd_en_o,
    output logic [ADDR_W-1:0]   mem_rd_addr_o,
    input  logic [2*DATA_W-1:0] mem_rd_data_i,
    output logic                mem_wr_en_o,
    output logic [ADDR_W-1:0]   mem_wr_addr_o,
    output logic [2*DATA_W-1:0] mem_wr_data_o,
    output logic [DATA_W-1:0]   add_a_o,
    output logic [DATA_W-1:0]   add_b_o,
    input  logic [DATA_W-1:0]   add_sum_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_ADD, S_WRITE, S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   rd_ptr, rd_end, wr_ptr;
    logic                half_sel, last;
    logic [2*DATA_W-1:0] buffer;
    logic [DATA_W-1:0]   a_reg, b_reg;
    logic                at_end;

    // Termination uses the latched end address, so rd_end = all-ones cannot run away on wrap.
    assign at_end = (rd_ptr == rd_end);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i)
                         state_nxt = (rd_end_addr_i < rd_start_addr_i) ? S_DONE : S_READ;
            S_READ:  state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_ADD;
            S_ADD:   state_nxt = (half_sel || at_end) ? S_WRITE : S_READ;
            S_WRITE: state_nxt = last ? S_DONE : S_READ;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            rd_end   <= '0;
            wr_ptr   <= '0;
            half_sel <= 1'b0;
            last     <= 1'b0;
            buffer   <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_i) begin
                    rd_ptr   <= rd_start_addr_i;
                    rd_end   <= rd_end_addr_i;
                    wr_ptr   <= wr_start_addr_i;
                    half_sel <= 1'b0;
                    last     <= 1'b0;
                    buffer   <= '0;
                end
                S_WAIT: begin
                    a_reg <= mem_rd_data_i[DATA_W-1:0];
                    b_reg <= mem_rd_data_i[2*DATA_W-1:DATA_W];
                end
                S_ADD: begin
                    if (half_sel) buffer[2*DATA_W-1:DATA_W] <= add_sum_i;
                    else          buffer[DATA_W-1:0]        <= add_sum_i;
                    half_sel <= ~half_sel;
                    last     <= at_end;
                    rd_ptr   <= rd_ptr + 1'b1;
                end
                S_WRITE: begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    buffer   <= '0;
                    half_sel <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy_o        = (state != S_IDLE);
        done_o        = (state == S_DONE);
        mem_rd_en_o   = (state == S_READ);
        mem_rd_addr_o = (state == S_READ) ? rd_ptr : '0;
        mem_wr_en_o   = (state == S_WRITE);
        mem_wr_addr_o = (state == S_WRITE) ? wr_ptr : '0;
        mem_wr_data_o = (state == S_WRITE) ? buffer : '0;
        add_a_o       = a_reg;
        add_b_o       = b_reg;
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural operand/result memory and adder, vector table plus
// hand-written reset and start-while-busy sequences.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  rs, re, ws;
    logic        busy, done, rd_en, wr_en;
    logic [9:0]  rd_addr, wr_addr;
    logic [63:0] rd_data, wr_data;
    logic [31:0] add_a, add_b, add_sum;

    logic [63:0] mem [1024];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    int          done_q[$];
    logic [9:0]  wa_q[$];
    logic [63:0] wd_q[$];
    int          rd_cnt, busy_cnt;

    always #5 clk = ~clk;

    calc_sequencer dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rd_start_addr_i(rs), .rd_end_addr_i(re), .wr_start_addr_i(ws),
        .busy_o(busy), .done_o(done),
        .mem_rd_en_o(rd_en), .mem_rd_addr_o(rd_addr), .mem_rd_data_i(rd_data),
        .mem_wr_en_o(wr_en), .mem_wr_addr_o(wr_addr), .mem_wr_data_o(wr_data),
        .add_a_o(add_a), .add_b_o(add_b), .add_sum_i(add_sum)
    );

    assign add_sum = add_a + add_b;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (busy)  busy_cnt++;
            if (rd_en) rd_cnt++;
            if (done)  done_q.push_back(cyc);
            if (wr_en) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        done_q.delete();
        wa_q.delete();
        wd_q.delete();
        rd_cnt   = 0;
        busy_cnt = 0;
    endtask

    // Launches a run; t1 is the cycle index (as seen by the monitor) of cycle T+1.
    task automatic launch(input logic [9:0] s, input logic [9:0] e, input logic [9:0] w,
                          output int t1);
        @(negedge clk);
        clear_logs();
        rs = s; re = e; ws = w; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t1 = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({tag, ".done_seen"}, done_q.size() != 0, 1'b1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".busy"}, busy, 1'b0);
        chk({tag, ".outs"},
            {done, rd_en, rd_addr, wr_en, wr_addr, wr_data, add_a, add_b} != '0, 1'b0);
    endtask

    typedef struct {
        logic [9:0]  s, e, w;
        int          nrd, nwr, lat;
        logic [9:0]  wa0, wa1;
        logic [63:0] wd0, wd1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t1;
        string tag;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0]    = {32'd2, 32'd1};
        mem[1]    = {32'd7, 32'd5};
        mem[4]    = {32'd1, 32'hFFFF_FFFF};
        mem[5]    = {32'd4, 32'd3};
        mem[6]    = {32'd20, 32'd10};
        mem[1023] = {32'h100, 32'h23};

        //          s     e     w     nrd nwr lat wa0   wa1  wd0                    wd1
        vecs[0] = '{10'd0, 10'd1, 10'd16, 2, 1, 8, 10'd16, 10'd0,
                    {32'd12, 32'd3}, 64'd0};
        vecs[1] = '{10'd4, 10'd6, 10'd0, 3, 2, 12, 10'd0, 10'd1,
                    {32'd7, 32'd0}, {32'd0, 32'd30}};
        vecs[2] = '{10'd5, 10'd4, 10'd9, 0, 0, 1, 10'd0, 10'd0, 64'd0, 64'd0};
        vecs[3] = '{10'd1023, 10'd1023, 10'd1023, 1, 1, 5, 10'd1023, 10'd0,
                    {32'd0, 32'h123}, 64'd0};
        vecs[4] = '{10'd4, 10'd6, 10'd1023, 3, 2, 12, 10'd1023, 10'd0,
                    {32'd7, 32'd0}, {32'd0, 32'd30}};

        // Reset held two cycles with start asserted: nothing may start.
        rst = 1'b1; start = 1'b1; rs = 10'd0; re = 10'd1; ws = 10'd0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b0; start = 1'b0;
        clear_logs();
        repeat (2) @(negedge clk);
        chk("reset.no_start", busy_cnt + rd_cnt, 0);

        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("vec%0d", i);
            launch(vecs[i].s, vecs[i].e, vecs[i].w, t1);
            wait_done(tag);
            if (done_q.size() != 0)
                chk({tag, ".done_cyc"}, done_q[0], t1 + vecs[i].lat - 1);
            chk({tag, ".done_pulses"}, done_q.size(), 1);
            chk({tag, ".busy_cycles"}, busy_cnt, vecs[i].lat);
            chk({tag, ".reads"}, rd_cnt, vecs[i].nrd);
            chk({tag, ".writes"}, wa_q.size(), vecs[i].nwr);
            if (vecs[i].nwr > 0 && wa_q.size() > 0) begin
                chk({tag, ".wr0_addr"}, wa_q[0], vecs[i].wa0);
                chk({tag, ".wr0_data"}, wd_q[0], vecs[i].wd0);
            end
            if (vecs[i].nwr > 1 && wa_q.size() > 1) begin
                chk({tag, ".wr1_addr"}, wa_q[1], vecs[i].wa1);
                chk({tag, ".wr1_data"}, wd_q[1], vecs[i].wd1);
            end
            chk({tag, ".idle_after"}, busy, 1'b0);
        end

        // start pulsed mid-run with different addresses must not disturb the run.
        launch(10'd0, 10'd1, 10'd16, t1);
        @(negedge clk);
        @(negedge clk);
        rs = 10'd4; re = 10'd6; ws = 10'd500; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        if (done_q.size() != 0) chk("busy_start.done_cyc", done_q[0], t1 + 7);
        chk("busy_start.writes", wa_q.size(), 1);
        if (wa_q.size() > 0) begin
            chk("busy_start.wr_addr", wa_q[0], 10'd16);
            chk("busy_start.wr_data", wd_q[0], {32'd12, 32'd3});
        end
        chk("busy_start.busy_cycles", busy_cnt, 8);

        // Reset during WAIT of the second pair (cycle T+5) aborts the run silently.
        launch(10'd4, 10'd6, 10'd0, t1);
        repeat (5) @(negedge clk);
        chk("abort.in_wait_cyc", cyc, t1 + 4);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_zero("abort");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort.no_write", wa_q.size(), 0);
        chk("abort.no_done", done_q.size(), 0);
        chk("abort.reads", rd_cnt, 2);
        chk("abort.idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
